// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle adder that sums WIDTH-bit operands CHUNK bits per
// clock edge, with a valid/ready handshake on the input and the output.
//
// Parameters
//   WIDTH  operand and sum width in bits
//   CHUNK  bits added per cycle; WIDTH must be an integer multiple of CHUNK
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   operands presented
//   in_ready   block can accept operands (high only in IDLE)
//   a, b       unsigned operands
//   cin        carry-in to bit 0
//   out_valid  result available (high only in DONE)
//   out_ready  consumer takes the result
//   sum        registered result bits
//   cout       registered carry-out of bit WIDTH-1
//   sub        (only with CHUNKED_ADDER_SUB_EN) subtract: A + ~B + 1, cin ignored
//
// Configuration
//   CHUNKED_ADDER_SUB_EN  when defined, adds the sub port and subtract mode.
//
// Operation: a capture edge in IDLE moves to BUSY; each BUSY edge adds one
// chunk (least significant first) and the N-th BUSY edge enters DONE, so
// out_valid rises N = WIDTH/CHUNK edges after capture. DONE holds the result
// until out_ready, then returns to IDLE (one operation per N+2 cycles).

module chunked_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CHUNKED_ADDER_SUB_EN
  ,
  input  logic             sub
`endif
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_nxt;

  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [KW-1:0]    k_q;

  logic             capture;
  logic             step;
  logic             last;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_add;
  logic [WIDTH-1:0] sum_nxt;
  logic [WIDTH-1:0] b_eff;
  logic             carry_init;

  // Operand B and initial carry as seen by the adder (subtract inverts B, carry 1)
`ifdef CHUNKED_ADDER_SUB_EN
  always_comb begin
    b_eff      = sub ? ~b : b;
    carry_init = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    b_eff      = b;
    carry_init = cin;
  end
`endif

  // Next-state and control strobes
  always_comb begin
    state_nxt = state_q;
    capture   = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          capture   = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (k_q == KW'(N - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; handshake flags are registered copies of the state decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  // Select chunk k of the captured operands and add it with the stored carry
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
    chunk_add = (CHUNK+1)'(a_chunk) + (CHUNK+1)'(b_chunk) + (CHUNK+1)'(carry_q);
  end

  // Merge the chunk result into its slot of the sum
  always_comb begin
    sum_nxt = sum;
    for (int unsigned i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        sum_nxt[i*CHUNK +: CHUNK] = chunk_add[CHUNK-1:0];
      end
    end
  end

  // Datapath: operand capture, per-chunk accumulation, final carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (capture) begin
      a_q     <= a;
      b_q     <= b_eff;
      carry_q <= carry_init;
      k_q     <= '0;
    end else if (step) begin
      sum     <= sum_nxt;
      carry_q <= chunk_add[CHUNK];
      if (last) begin
        cout <= chunk_add[CHUNK];
        k_q  <= '0;
      end else begin
        k_q <= k_q + KW'(1);
      end
    end
  end

endmodule

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands presented.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  operand A, unsigned.
REQ-008 SHALL have port b  input  WIDTH  operand B, unsigned.
REQ-009 SHALL have port cin  input  1  carry-in to bit 0.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port sum  output  WIDTH  registered result bits.
REQ-013 SHALL have port cout  output  1  registered carry-out of bit WIDTH-1.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; N = WIDTH/CHUNK.
REQ-015 SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE, both decoded from state.
REQ-016 In IDLE, on an edge with in_valid && in_ready, SHALL capture a, b and cin, clear chunk counter to 0, and go to BUSY.
REQ-017 In BUSY, each edge SHALL add chunk k of the captured A and B plus the stored carry, write CHUNK bits into sum[k*CHUNK +: CHUNK], store the chunk carry-out, and increment k.
REQ-018 On the BUSY edge where k = N-1, SHALL load cout with the final carry and go to DONE; out_valid rises exactly N edges after the capture edge.
REQ-019 In DONE, sum and cout SHALL hold stable until an edge with out_ready = 1, which returns the FSM to IDLE.
REQ-020 in_valid and operand changes during BUSY or DONE SHALL be ignored, and operand changes after capture SHALL NOT affect the result.
REQ-021 Result SHALL equal (A + B + cin) mod 2^WIDTH with cout = bit WIDTH of the full sum; all-ones + 1 SHALL wrap to 0 with cout = 1.
REQ-022 With CHUNK = WIDTH (N = 1), SHALL reach DONE one edge after capture.
REQ-023 out_ready high on the DONE-entry cycle SHALL be honoured on the next edge; no transfer is lost or duplicated.
REQ-024 Sustained throughput SHALL be one operation per N+2 cycles with out_ready held high.

Reset
REQ-025 While rst = 1, SHALL force state IDLE, chunk counter 0, stored carry 0, sum 0, cout 0, out_valid 0, and in_ready 1.
REQ-026 rst asserted in BUSY or DONE SHALL abort the operation immediately, and no out_valid SHALL appear for it.
REQ-027 in_valid during rst = 1 SHALL NOT capture operands.

Configuration
REQ-028 Macro CHUNKED_ADDER_SUB_EN SHALL, when defined, add port sub  input  1, captured with the operands.
REQ-029 With CHUNKED_ADDER_SUB_EN and captured sub = 1, SHALL compute A + ~B + 1 (cin ignored); cout = 1 means no borrow.
REQ-030 Without CHUNKED_ADDER_SUB_EN, the sub port SHALL NOT exist, and behaviour SHALL be addition only per REQ-021.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-031 a=0xFFFF, b=0x0001, cin=0 -> out_valid 4 edges after capture, sum=0x0000, cout=1.
REQ-032 a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; in_ready low from capture until return to IDLE.
REQ-033 out_ready held 0 for 10 cycles in DONE -> sum/cout/out_valid stable; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-034 rst pulsed at k=2 of a=0x00FF, b=0x0001 -> all outputs 0, in_ready=1, no out_valid; the next operation completes correctly.
REQ-035 CHUNKED_ADDER_SUB_EN defined, a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
REQ-036 WIDTH=16, CHUNK=16, a=0x8000, b=0x8000, cin=0 -> out_valid 1 edge after capture, sum=0x0000, cout=1.
